// File: rtl/uart_rx.sv
// UART receiver: oversamples RX_IN at PRESCALE clocks per bit, votes 3 mid-bit samples,
// checks optional parity and the stop bit, and reports each completed frame.
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR,
    output logic                  Busy
);
    localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] MID_LO   = CW'(PRESCALE / 2 - 1);
    localparam logic [CW-1:0] MID      = CW'(PRESCALE / 2);
    localparam logic [CW-1:0] MID_HI   = CW'(PRESCALE / 2 + 1);
    localparam logic [CW-1:0] LAST     = CW'(PRESCALE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic                  rx_meta_q, rx_s_q, rx_prev_q;
    state_t                state_q, state_d;
    logic [CW-1:0]         edge_q, edge_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [2:0]            samp_q, samp_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_en_q, par_en_d, par_typ_q, par_typ_d;
    logic                  perr_int_q, perr_int_d;
    logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
    logic                  valid_q, valid_d;
    logic                  par_err_q, par_err_d, stp_err_q, stp_err_d;

    logic start_det, bit_end, samp2, vote, frame_start;

    assign start_det = rx_prev_q & ~rx_s_q;
    assign bit_end   = (edge_q == LAST);
    // The third sample may land on the final count of the bit (PRESCALE=4), so take it live.
    assign samp2     = (edge_q == MID_HI) ? rx_s_q : samp_q[2];
    assign vote      = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp2) | (samp_q[1] & samp2);

    always_comb begin
        state_d     = state_q;
        edge_d      = '0;
        bit_d       = bit_q;
        samp_d      = samp_q;
        shift_d     = shift_q;
        par_en_d    = par_en_q;
        par_typ_d   = par_typ_q;
        perr_int_d  = perr_int_q;
        pdata_d     = pdata_q;
        valid_d     = 1'b0;
        par_err_d   = par_err_q;
        stp_err_d   = stp_err_q;
        frame_start = 1'b0;

        if (state_q != IDLE) begin
            edge_d = bit_end ? '0 : edge_q + CW'(1);
            if (edge_q == MID_LO) samp_d[0] = rx_s_q;
            if (edge_q == MID)    samp_d[1] = rx_s_q;
            if (edge_q == MID_HI) samp_d[2] = rx_s_q;
        end

        case (state_q)
            IDLE: begin
                if (start_det) begin
                    state_d     = START;
                    frame_start = 1'b1;
                end
            end
            START: begin
                if (bit_end) state_d = vote ? IDLE : DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = {vote, shift_q[DATA_WIDTH-1:1]};
                    bit_d   = bit_q + BW'(1);
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = par_en_q ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    perr_int_d = (^shift_q) ^ par_typ_q ^ vote;
                    state_d    = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    par_err_d = perr_int_q;
                    stp_err_d = ~vote;
                    if (!perr_int_q && vote) begin
                        pdata_d = shift_q;
                        valid_d = 1'b1;
                    end
                    state_d = IDLE;
                    // A start edge landing in the last stop cycle begins the next frame directly.
                    if (start_det) begin
                        state_d     = START;
                        frame_start = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (frame_start) begin
            par_en_d   = PAR_EN;
            par_typ_d  = PAR_TYP;
            perr_int_d = 1'b0;
            bit_d      = '0;
            edge_d     = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            rx_prev_q  <= 1'b1;
            state_q    <= IDLE;
            edge_q     <= '0;
            bit_q      <= '0;
            samp_q     <= '0;
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            perr_int_q <= 1'b0;
            pdata_q    <= '0;
            valid_q    <= 1'b0;
            par_err_q  <= 1'b0;
            stp_err_q  <= 1'b0;
        end else begin
            rx_meta_q  <= RX_IN;
            rx_s_q     <= rx_meta_q;
            rx_prev_q  <= rx_s_q;
            state_q    <= state_d;
            edge_q     <= edge_d;
            bit_q      <= bit_d;
            samp_q     <= samp_d;
            shift_q    <= shift_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            perr_int_q <= perr_int_d;
            pdata_q    <= pdata_d;
            valid_q    <= valid_d;
            par_err_q  <= par_err_d;
            stp_err_q  <= stp_err_d;
        end
    end

    assign P_DATA     = pdata_q;
    assign DATA_VALID = valid_q;
    assign PAR_ERR    = par_err_q;
    assign STP_ERR    = stp_err_q;
    assign Busy       = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are serialised here, expected words and their
// completion cycles are queued at send time and matched against each DATA_VALID pulse.
module tb_uart_rx;
    localparam int P = 8;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         RX_IN;
    logic         PAR_EN;
    logic         PAR_TYP;
    logic [W-1:0] P_DATA;
    logic         DATA_VALID;
    logic         PAR_ERR;
    logic         STP_ERR;
    logic         Busy;

    uart_rx #(.DATA_WIDTH(W), .PRESCALE(P)) dut (
        .clk(clk), .reset(reset), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
        .P_DATA(P_DATA), .DATA_VALID(DATA_VALID), .PAR_ERR(PAR_ERR),
        .STP_ERR(STP_ERR), .Busy(Busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        int           cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   pulses = 0;
    int   busy_run = 0;
    int   last_busy_run = 0;
    int   busy_rises = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Scoreboard and Busy-width monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (DATA_VALID === 1'b1) begin
            exp_t e;
            pulses++;
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("p_data_at_valid", 32'(P_DATA), 32'(e.d));
                chk("valid_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
        if (Busy === 1'b1) begin
            busy_run++;
        end else begin
            if (busy_run != 0) begin
                last_busy_run = busy_run;
                busy_rises++;
            end
            busy_run = 0;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic b);
        RX_IN = b;
        idle(P);
    endtask

    task automatic send_frame(input logic [W-1:0] d, input logic pen, input logic ptyp,
                              input logic flip_par, input logic stop_bit, input logic good);
        int n;
        exp_t e;
        n = pen ? W + 3 : W + 2;
        PAR_EN  = pen;
        PAR_TYP = ptyp;
        if (good) begin
            e.d   = d;
            e.cyc = cyc + 3 + n * P;
            exp_q.push_back(e);
        end
        drive_bit(1'b0);
        PAR_EN  = ~pen;
        PAR_TYP = ~ptyp;
        for (int i = 0; i < W; i++) drive_bit(d[i]);
        if (pen) drive_bit((^d) ^ ptyp ^ flip_par);
        drive_bit(stop_bit);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rises0, pulses0;
        reset   = 1'b0;
        RX_IN   = 1'b1;
        PAR_EN  = 1'b0;
        PAR_TYP = 1'b0;
        idle(3);
        reset = 1'b1;
        idle(100);
        chk("rst_p_data", 32'(P_DATA), 32'h0);
        chk("rst_valid", 32'(DATA_VALID), 32'h0);
        chk("rst_par_err", 32'(PAR_ERR), 32'h0);
        chk("rst_stp_err", 32'(STP_ERR), 32'h0);
        chk("rst_busy", 32'(Busy), 32'h0);
        chk("rst_no_pulse", 32'(pulses), 32'd0);

        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(20);
        chk("a5_drained", 32'(exp_q.size()), 32'd0);
        chk("a5_pulses", 32'(pulses), 32'd1);
        chk("a5_p_data", 32'(P_DATA), 32'hA5);
        chk("a5_par_err", 32'(PAR_ERR), 32'h0);
        chk("a5_stp_err", 32'(STP_ERR), 32'h0);
        chk("a5_busy_len", 32'(last_busy_run), 32'd80);

        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        send_frame(8'h81, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        idle(20);
        chk("b2b_drained", 32'(exp_q.size()), 32'd0);
        chk("b2b_pulses", 32'(pulses), 32'd3);
        chk("b2b_p_data", 32'(P_DATA), 32'h81);
        chk("b2b_busy_len", 32'(last_busy_run), 32'd176);

        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(20);
        chk("perr_flag", 32'(PAR_ERR), 32'h1);
        chk("perr_stp", 32'(STP_ERR), 32'h0);
        chk("perr_p_data_kept", 32'(P_DATA), 32'h81);
        chk("perr_no_pulse", 32'(pulses), 32'd3);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        idle(20);
        chk("perr_cleared", 32'(PAR_ERR), 32'h0);
        chk("good_after_perr", 32'(P_DATA), 32'h5A);

        rises0  = busy_rises;
        pulses0 = pulses;
        send_frame(8'hF7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(200);
        chk("serr_flag", 32'(STP_ERR), 32'h1);
        chk("serr_par", 32'(PAR_ERR), 32'h0);
        chk("serr_p_data_kept", 32'(P_DATA), 32'h5A);
        chk("serr_no_pulse", 32'(pulses), 32'(pulses0));
        chk("break_one_frame", 32'(busy_rises), 32'(rises0 + 1));
        chk("break_idle", 32'(Busy), 32'h0);
        RX_IN = 1'b1;
        idle(20);

        RX_IN = 1'b0;
        idle(2);
        RX_IN = 1'b1;
        idle(30);
        chk("glitch_busy_len", 32'(last_busy_run), 32'd8);
        chk("glitch_stp_kept", 32'(STP_ERR), 32'h1);
        chk("glitch_par_kept", 32'(PAR_ERR), 32'h0);
        chk("glitch_p_data", 32'(P_DATA), 32'h5A);
        chk("glitch_no_pulse", 32'(pulses), 32'(pulses0));

        PAR_EN = 1'b0;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        chk("mid_busy", 32'(Busy), 32'h1);
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(Busy), 32'h0);
        chk("mid_rst_p_data", 32'(P_DATA), 32'h0);
        chk("mid_rst_stp", 32'(STP_ERR), 32'h0);
        chk("mid_rst_valid", 32'(DATA_VALID), 32'h0);
        RX_IN = 1'b1;
        idle(2);
        reset = 1'b1;
        idle(100);
        chk("post_rst_no_pulse", 32'(pulses), 32'(pulses0));
        chk("post_rst_busy", 32'(Busy), 32'h0);

        send_frame(8'h0F, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        idle(20);
        chk("final_drained", 32'(exp_q.size()), 32'd0);
        chk("final_p_data", 32'(P_DATA), 32'h0F);
        chk("final_pulses", 32'(pulses), 32'(pulses0 + 1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver that turns a serial line back into parallel words, the receive-side counterpart of the UART transmitter. It oversamples `RX_IN` at `PRESCALE` clocks per bit, takes a 3-sample majority vote at mid-bit, checks optional parity and the stop bit, and reports each completed frame. It sits between the board-level serial pin and the parallel consumer, and uses the same frame format and parity convention as the transmitter (`PAR_EN`, `PAR_TYP`).

## Interface
Parameters:
- `DATA_WIDTH`, default 8: data bits per frame.
- `PRESCALE`, default 8: clk cycles per bit. Must be even and ≥ 4.

Ports:
- `clk`  in  1: single clock. All logic is on its rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `RX_IN`  in  1: serial line, idle high. Asynchronous to `clk`.
- `PAR_EN`  in  1: 1 means the frame carries a parity bit.
- `PAR_TYP`  in  1: 0 = even parity, 1 = odd parity.
- `P_DATA`  out  `DATA_WIDTH`: last good received word.
- `DATA_VALID`  out  1: one-cycle pulse when a good frame completes.
- `PAR_ERR`  out  1: parity error flag for the last completed frame.
- `STP_ERR`  out  1: stop-bit error flag for the last completed frame.
- `Busy`  out  1: high while a frame is being received.

## Operation
Input synchronizer:
- `RX_IN` passes through a 2-flop synchronizer to give `rx_s`. Both flops reset to 1.
- `rx_prev` holds the previous value of `rx_s`, reset to 1.

Frame format:
- Start bit (0), then `DATA_WIDTH` data bits LSB first, then a parity bit if `PAR_EN`, then a stop bit (1).
- Frame length is N = `DATA_WIDTH`+2, or `DATA_WIDTH`+3 with parity.

Counters:
- `edge_cnt` runs 0..`PRESCALE`-1 within each bit and wraps to 0 at the end of the bit.
- `bit_cnt` indexes the data bits.
- `rx_s` is sampled at `edge_cnt` = P/2-1, P/2 and P/2+1, where P = `PRESCALE`. The bit value is the majority of the three samples.

FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: a falling edge (`rx_prev`=1, `rx_s`=0) is a start detection. That cycle counts as `edge_cnt`=0. The FSM moves to START, captures `PAR_EN`/`PAR_TYP` for the whole frame, and raises `Busy` from the next cycle.
- START: if the majority vote is 1, the low pulse was a glitch. Return to IDLE at the end of the bit with no outputs changed and no flags updated. Otherwise go to DATA.
- DATA: shift bits into the shift register LSB first. After bit `DATA_WIDTH`-1, go to PARITY if parity is enabled, else to STOP.
- PARITY: expected parity bit = XOR of the data bits XOR `PAR_TYP`. A mismatch sets the internal parity-error bit.
- STOP: a majority vote of 0 sets the internal stop-error bit. At the end of the bit (`edge_cnt`=P-1):
  - update `PAR_ERR` and `STP_ERR`;
  - if both are 0, load `P_DATA` and pulse `DATA_VALID`;
  - go to IDLE.
- If the frame has an error, `P_DATA` keeps its old value and `DATA_VALID` stays 0.
- After a stop error, a new frame needs a fresh 1→0 edge. A line held low (break) produces exactly one frame.

## Timing
- Reset values: `P_DATA`=0, `DATA_VALID`=0, `PAR_ERR`=0, `STP_ERR`=0, `Busy`=0. FSM in IDLE, counters 0.
- Reset during a frame discards the partial frame immediately. No pulse is produced.
- Let D be the clk edge at which `rx_s` is first seen low in IDLE. D is 2 edges after the edge that first captures `RX_IN` low.
- Outputs update at edge D+N·P. `DATA_VALID` is high for exactly the one cycle after that edge.
- `PAR_ERR` and `STP_ERR` hold their values until the next completed frame. A glitch-rejected start does not change them.
- `Busy` is high from edge D+1 through edge D+N·P, then low.
- Back-to-back frames: a start edge arriving in the cycle after the FSM returns to IDLE is detected. No idle gap is required.
- Changes on `PAR_EN`/`PAR_TYP` during a frame have no effect on that frame.

## Test plan
All scenarios use `PRESCALE`=8 and `DATA_WIDTH`=8.
- Reset, then line idle 100 cycles → all outputs 0, no `DATA_VALID`.
- Frame 0xA5 with `PAR_EN`=0 → `DATA_VALID` pulses once at D+80, `P_DATA`=0xA5, `PAR_ERR`=`STP_ERR`=0, `Busy` high for 80 cycles.
- Frame 0x3C with `PAR_EN`=1, `PAR_TYP`=0, parity bit 0, immediately followed by frame 0x81 with odd parity and parity bit 1 → two pulses 88 cycles apart, `P_DATA` 0x3C then 0x81.
- Frame 0x3C, even parity, wrong parity bit 1 → no `DATA_VALID`, `PAR_ERR`=1, `P_DATA` unchanged. Next good frame clears `PAR_ERR`.
- Stop bit driven 0 → `STP_ERR`=1, no pulse. Line then held low for 200 cycles → no further frames.
- Low glitch of 2 cycles on an idle line → `Busy` high for 8 cycles, then IDLE, no flag change. Separately, reset asserted mid-frame → outputs return to reset values and no pulse follows.
